// File: rtl/pulse_train_pkg.sv
// Shared types and helpers for the pulse train generator.
package pulse_train_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int unsigned at_least_one(input int unsigned x);
        return (x == 0) ? 1 : x;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter timing one HIGH or LOW phase; zero flags the phase's last cycle.
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && count_q != '0)
            count_d = count_q - W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Emits a burst of pulse_count pulses with programmable high/low widths.
// Define PULSE_TRAIN_ABORT_EN to add an abort input that cuts a burst short.
module pulse_train_generator
    import pulse_train_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] pulse_count,
    input  logic [W-1:0] high_cycles,
    input  logic [W-1:0] low_cycles,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic         abort,
`endif
    output logic         pulse_out,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] pulses_sent
);

    state_e       state_q, state_d;
    logic         pulse_q, pulse_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [N-1:0] sent_q, sent_d;
    logic [N-1:0] remain_q, remain_d;
    logic [W-1:0] hcfg_q, hcfg_d;
    logic [W-1:0] lcfg_q, lcfg_d;

    logic         tmr_load, tmr_dec, tmr_zero;
    logic [W-1:0] tmr_val;

    // Timer reload value: a zero width still lasts one cycle.
    function automatic logic [W-1:0] eff_m1(input logic [W-1:0] x);
        return W'(at_least_one(32'(x)) - 1);
    endfunction

    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sent_d   = sent_q;
        remain_d = remain_q;
        hcfg_d   = hcfg_q;
        lcfg_d   = lcfg_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: if (start) begin
                hcfg_d = high_cycles;
                lcfg_d = low_cycles;
                if (pulse_count != '0) begin
                    state_d  = HIGH;
                    pulse_d  = 1'b1;
                    busy_d   = 1'b1;
                    sent_d   = N'(1);
                    remain_d = pulse_count - N'(1);
                    tmr_load = 1'b1;
                    tmr_val  = eff_m1(high_cycles);
                end else begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    sent_d   = '0;
                    remain_d = '0;
                end
            end
            HIGH: if (tmr_zero) begin
                state_d  = LOW;
                pulse_d  = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = eff_m1(lcfg_q);
            end else begin
                tmr_dec = 1'b1;
            end
            LOW: if (tmr_zero) begin
                if (remain_q != '0) begin
                    state_d  = HIGH;
                    pulse_d  = 1'b1;
                    sent_d   = sent_q + N'(1);
                    remain_d = remain_q - N'(1);
                    tmr_load = 1'b1;
                    tmr_val  = eff_m1(hcfg_q);
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
                tmr_dec = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef PULSE_TRAIN_ABORT_EN
        // Abort wins over any phase transition on the same edge.
        if (abort && (state_q == HIGH || state_q == LOW)) begin
            state_d  = DONE;
            pulse_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            sent_d   = sent_q;
            remain_d = remain_q;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= '0;
            remain_q <= '0;
            hcfg_q   <= '0;
            lcfg_q   <= '0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sent_q   <= sent_d;
            remain_q <= remain_d;
            hcfg_q   <= hcfg_d;
            lcfg_q   <= lcfg_d;
        end
    end

    phase_timer #(.W(W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign pulse_out   = pulse_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: vector table plus hand-written corner sequences.
module tb_pulse_train_generator;

    localparam int N = 8;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] pulse_count = '0;
    logic [W-1:0] high_cycles = '0;
    logic [W-1:0] low_cycles = '0;
    logic         abort = 1'b0;
    logic         pulse_out, busy, done;
    logic [N-1:0] pulses_sent;

    int n_cmp = 0;
    int n_err = 0;
    int edges = 0;
    logic prev_pulse = 1'b0;

    pulse_train_generator #(.N(N), .W(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .pulse_count (pulse_count),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
`ifdef PULSE_TRAIN_ABORT_EN
        .abort       (abort),
`endif
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    always #5 clk = ~clk;

    // Reference edge counter watching pulse_out, as a downstream detector would.
    always @(negedge clk) begin
        if (pulse_out && !prev_pulse) edges <= edges + 1;
        prev_pulse <= pulse_out;
    end

    typedef struct {
        int pc;
        int hi;
        int lo;
        int busy_len;
        int sent;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a burst from IDLE and check it cycle by cycle through the done strobe.
    task automatic run_burst(input int pc, input int hi, input int lo, input int blen, input int sent);
        int he, le, e0;
        he = (hi == 0) ? 1 : hi;
        le = (lo == 0) ? 1 : lo;
        pulse_count = N'(pc);
        high_cycles = W'(hi);
        low_cycles  = W'(lo);
        start = 1'b1;
        tick();
        start = 1'b0;
        e0 = edges;
        for (int i = 0; i < blen; i++) begin
            chk("pulse_out", int'(pulse_out), ((i % (he + le)) < he) ? 1 : 0);
            chk("busy", int'(busy), 1);
            chk("sent_mid", int'(pulses_sent), i / (he + le) + 1);
            chk("done_mid", int'(done), 0);
            tick();
        end
        chk("done_strobe", int'(done), 1);
        chk("busy_end", int'(busy), 0);
        chk("pulse_end", int'(pulse_out), 0);
        chk("sent_end", int'(pulses_sent), sent);
        tick();
        chk("done_one_cycle", int'(done), 0);
        chk("edge_count", edges - e0, sent);
        chk("sent_hold", int'(pulses_sent), sent);
    endtask

    initial begin
        vecs[0] = '{pc: 3,   hi: 2, lo: 3, busy_len: 15,  sent: 3};
        vecs[1] = '{pc: 0,   hi: 5, lo: 5, busy_len: 0,   sent: 0};
        vecs[2] = '{pc: 4,   hi: 0, lo: 0, busy_len: 8,   sent: 4};
        vecs[3] = '{pc: 1,   hi: 1, lo: 1, busy_len: 2,   sent: 1};
        vecs[4] = '{pc: 2,   hi: 3, lo: 0, busy_len: 8,   sent: 2};
        vecs[5] = '{pc: 5,   hi: 1, lo: 2, busy_len: 15,  sent: 5};
        vecs[6] = '{pc: 255, hi: 1, lo: 1, busy_len: 510, sent: 255};

        #12;
        chk("rst_pulse", int'(pulse_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sent", int'(pulses_sent), 0);
        @(negedge clk) reset_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++)
            run_burst(vecs[v].pc, vecs[v].hi, vecs[v].lo, vecs[v].busy_len, vecs[v].sent);

        // Restart attempts mid-burst and during DONE must be ignored.
        pulse_count = 8'd3; high_cycles = 16'd2; low_cycles = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 4) begin
                start = 1'b1; pulse_count = 8'd7; high_cycles = 16'd1; low_cycles = 16'd1;
            end
            chk("mid_pulse", int'(pulse_out), ((i % 5) < 2) ? 1 : 0);
            chk("mid_busy", int'(busy), 1);
            tick();
        end
        chk("mid_done", int'(done), 1);
        chk("mid_sent", int'(pulses_sent), 3);
        tick();
        chk("done_start_ignored_busy", int'(busy), 0);
        chk("done_start_ignored_pulse", int'(pulse_out), 0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            chk("new_pulse", int'(pulse_out), (i % 2 == 0) ? 1 : 0);
            chk("new_busy", int'(busy), 1);
            tick();
        end
        chk("new_done", int'(done), 1);
        chk("new_sent", int'(pulses_sent), 7);
        tick();

        // Asynchronous reset during the second pulse of a 5-pulse burst.
        pulse_count = 8'd5; high_cycles = 16'd3; low_cycles = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst_pulse", int'(pulse_out), 1);
        chk("pre_rst_sent", int'(pulses_sent), 2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_pulse", int'(pulse_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_sent", int'(pulses_sent), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", int'(done), 0);
        end
        @(negedge clk) reset_n = 1'b1;
        tick();
        chk("post_rst_idle", int'(busy), 0);
        run_burst(2, 1, 2, 6, 2);

`ifdef PULSE_TRAIN_ABORT_EN
        // Abort during the third high phase.
        pulse_count = 8'd5; high_cycles = 16'd2; low_cycles = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("abort_pre_pulse", int'(pulse_out), 1);
        chk("abort_pre_sent", int'(pulses_sent), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", int'(done), 1);
        chk("abort_pulse", int'(pulse_out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sent", int'(pulses_sent), 3);
        tick();
        chk("abort_done_once", int'(done), 0);
        chk("abort_sent_hold", int'(pulses_sent), 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
